operand_fetch: RTL and testbench

//  Execute-stage operand front end: holds the 32-entry integer register file and picks ALU operands.

---
 rtl/operand_fetch.sv | 126 ++++++++++++
 tb/tb_operand_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Execute-stage operand front end: integer register file with writeback bypass,
// ALU operand selection and a 1-deep valid/ready output register.
module operand_fetch #(
    parameter int WORDSIZE = 64,
    parameter int REGCOUNT = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [4:0]          rd,
    input  logic [WORDSIZE-1:0] pc,
    input  logic [WORDSIZE-1:0] imm,
    input  logic                src_a_sel,
    input  logic                src_b_sel,
    input  logic [2:0]          alu_op,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [4:0]          wb_rd,
    input  logic [WORDSIZE-1:0] wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] out_a,
    output logic [WORDSIZE-1:0] out_b,
    output logic [2:0]          out_op,
    output logic [4:0]          out_rd,
    output logic [WORDSIZE-1:0] out_rs2_val
);

    logic [WORDSIZE-1:0] regs_q [REGCOUNT];
    logic [WORDSIZE-1:0] regs_d [REGCOUNT];

    logic                out_valid_q, out_valid_d;
    logic [WORDSIZE-1:0] out_a_q, out_a_d;
    logic [WORDSIZE-1:0] out_b_q, out_b_d;
    logic [2:0]          out_op_q, out_op_d;
    logic [4:0]          out_rd_q, out_rd_d;
    logic [WORDSIZE-1:0] out_rs2_val_q, out_rs2_val_d;

    logic [WORDSIZE-1:0] rs1_val, rs2_val;
    logic                accept;
    logic                wb_write;

    assign wb_write = wb_en && (wb_rd != 5'd0);

    // Register file next state; x0 is never written so it stays zero.
    always_comb begin
        for (int i = 0; i < REGCOUNT; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_write) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    // Same-cycle writeback is forwarded so the operand sees the newest value.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = (wb_write && wb_rd == rs1) ? wb_data : regs_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = (wb_write && wb_rd == rs2) ? wb_data : regs_q[rs2];
        end
    end

    assign in_ready = !reset && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_op_d      = out_op_q;
        out_rd_d      = out_rd_q;
        out_rs2_val_d = out_rs2_val_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_a_d       = src_a_sel ? pc  : rs1_val;
            out_b_d       = src_b_sel ? imm : rs2_val;
            out_op_d      = alu_op;
            out_rd_d      = rd;
            out_rs2_val_d = rs2_val;
        end else if (out_ready) begin
            // Consumed with nothing new: drop valid, keep last data visible.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGCOUNT; i++) begin
                regs_q[i] <= '0;
            end
            out_valid_q   <= 1'b0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_op_q      <= '0;
            out_rd_q      <= '0;
            out_rs2_val_q <= '0;
        end else begin
            for (int i = 0; i < REGCOUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
            out_valid_q   <= out_valid_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_op_q      <= out_op_d;
            out_rd_q      <= out_rd_d;
            out_rs2_val_q <= out_rs2_val_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_op      = out_op_q;
    assign out_rd      = out_rd_q;
    assign out_rs2_val = out_rs2_val_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: register file, bypass, handshake, stall and flush.
module tb_operand_fetch;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   rs1, rs2, rd;
    logic [W-1:0] pc, imm;
    logic         src_a_sel, src_b_sel;
    logic [2:0]   alu_op;
    logic         flush;
    logic         wb_en;
    logic [4:0]   wb_rd;
    logic [W-1:0] wb_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a, out_b, out_rs2_val;
    logic [2:0]   out_op;
    logic [4:0]   out_rd;

    int checks = 0;
    int passes = 0;

    operand_fetch #(.WORDSIZE(W), .REGCOUNT(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .pc(pc), .imm(imm),
        .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .alu_op(alu_op),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
        .out_rs2_val(out_rs2_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic [2:0] op);
        in_valid = 1'b1;
        rs1 = a; rs2 = b; rd = d; alu_op = op;
        src_a_sel = 1'b0; src_b_sel = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        pc = '0; imm = '0; src_a_sel = 1'b0; src_b_sel = 1'b0; alu_op = '0;
        flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;

        // Reset state
        step(); step();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_a", out_a, 0);
        check("reset_out_b", out_b, 0);
        check("reset_out_op", out_op, 0);
        check("reset_out_rd", out_rd, 0);
        check("reset_out_rs2", out_rs2_val, 0);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);

        // 1: basic issue after writeback
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h10; step();
        wb_rd = 5'd6; wb_data = 64'h3; step();
        wb_en = 1'b0;
        issue(5'd5, 5'd6, 5'd12, 3'b001);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_a", out_a, 64'h10);
        check("t1_b", out_b, 64'h3);
        check("t1_op", out_op, 3'b001);
        check("t1_rd", out_rd, 5'd12);
        check("t1_rs2", out_rs2_val, 64'h3);

        // Consume with no new instruction: valid drops, data holds
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);
        check("drain_a_hold", out_a, 64'h10);

        // 2: x0 writes ignored, including same-cycle bypass
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
        issue(5'd0, 5'd0, 5'd1, 3'b000);
        step();
        check("t2_a_bypass_x0", out_a, 0);
        check("t2_b_bypass_x0", out_b, 0);
        wb_en = 1'b0;
        step();
        check("t2_a_after", out_a, 0);

        // 3: bypass of a real register, then the write must have landed
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hABC;
        issue(5'd7, 5'd7, 5'd3, 3'b010);
        step();
        check("t3_a_bypass", out_a, 64'hABC);
        check("t3_rs2_bypass", out_rs2_val, 64'hABC);
        wb_en = 1'b0;
        issue(5'd7, 5'd5, 5'd3, 3'b010);
        step();
        check("t3_a_stored", out_a, 64'hABC);
        check("t3_b_stored", out_b, 64'h10);

        // 4: stall for 3 cycles, then release
        issue(5'd5, 5'd6, 5'd8, 3'b011);
        step();
        check("t4_first_a", out_a, 64'h10);
        out_ready = 1'b0;
        issue(5'd6, 5'd5, 5'd9, 3'b100);
        #1;
        check("t4_in_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_a", out_a, 64'h10);
            check("t4_stall_op", out_op, 3'b011);
            check("t4_stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("t4_release_in_ready", in_ready, 1);
        step();
        check("t4_next_valid", out_valid, 1);
        check("t4_next_a", out_a, 64'h3);
        check("t4_next_op", out_op, 3'b100);
        check("t4_next_rd", out_rd, 5'd9);

        // 5: pc / immediate selection
        issue(5'd5, 5'd6, 5'd2, 3'b000);
        src_a_sel = 1'b1; src_b_sel = 1'b1;
        pc = 64'h400; imm = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        check("t5_a_pc", out_a, 64'h400);
        check("t5_b_imm", out_b, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_rs2_raw", out_rs2_val, 64'h3);

        // 6: flush drops the accepted instruction; writeback still lands
        issue(5'd5, 5'd6, 5'd4, 3'b001);
        flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h1;
        #1;
        check("t6_in_ready_flush", in_ready, 1);
        step();
        check("t6_valid_flushed", out_valid, 0);
        flush = 1'b0; wb_en = 1'b0;
        issue(5'd9, 5'd0, 5'd4, 3'b111);
        step();
        check("t6_valid", out_valid, 1);
        check("t6_x9", out_a, 64'h1);
        check("t6_op_undef_pass", out_op, 3'b111);

        // Reset mid-run clears outputs and the register file
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst2_in_ready", in_ready, 0);
        step();
        check("rst2_valid", out_valid, 0);
        check("rst2_a", out_a, 0);
        reset = 1'b0;
        issue(5'd5, 5'd7, 5'd1, 3'b000);
        step();
        check("rst2_x5_cleared", out_a, 0);
        check("rst2_x7_cleared", out_b, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
